pref_issue_queue: RTL
=====================

# pref_issue_queue

Receive-side buffer for the stride prefetcher's degree-3 output. Each cycle it accepts up to three prefetch candidates, block-aligns them, optionally filters duplicates, and stores them in a FIFO. It then issues them one at a time to the L2/memory request port over a valid/ready handshake. It sits between the prefetcher and the cache miss path, and absorbs bursts of three candidates per cycle against a downstream that can take one request per cycle.

## Interface
- DEPTH, 8, FIFO entries; power of two, 4..32
- ADDR_SIZE, 64, address width in bits
- LOG2_BLOCK_SIZE, 6, log2 of cache block size in bytes
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-low; clears all state
- pref_addr1_i / pref_addr2_i / pref_addr3_i  input  ADDR_SIZE  prefetch candidates in priority order 1, 2, 3
- pref_valid1_i / pref_valid2_i / pref_valid3_i  input  1  candidate qualifiers; each is independent
- issue_valid_o  output  1  head entry is available
- issue_addr_o  output  ADDR_SIZE  head entry address, block-aligned
- issue_ready_i  input  1  downstream accepts the head this cycle
- occupancy_o  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- drop_count_o  output  16  saturating count of candidates dropped for lack of space

## Operation
- Alignment: each candidate has bits [LOG2_BLOCK_SIZE-1:0] forced to 0 before any compare or store.
- Candidates are evaluated in order 1, 2, 3. A candidate with valid low is ignored.
- Duplicate filter (see Configuration): a valid candidate is discarded silently if its aligned address equals either of the following:
  - any valid FIFO entry, including a head that is popping this cycle;
  - an earlier candidate accepted in the same cycle.
- Space is free = DEPTH − occupancy, taken at the start of the cycle. A pop in the same cycle does NOT create space until the next cycle.
- Surviving candidates are enqueued in order until free space is exhausted. Each remaining survivor increments drop_count_o by 1, saturating at 16'hFFFF. Existing entries are never overwritten.
- Pop: when issue_valid_o && issue_ready_i, the head is removed.
- Storage is a circular buffer with head/tail pointers that wrap modulo DEPTH, plus an explicit occupancy counter.
- Each cycle: occupancy_next = occupancy + enq_count − pop, where enq_count is 0..3.
- issue_valid_o = (occupancy != 0). issue_addr_o = entry[head]. Both are driven directly from registers, with no combinational path from the inputs.
- issue_addr_o is held stable while issue_valid_o is high and issue_ready_i is low.

## Timing
- Reset (rst low, asynchronous) clears the following:
  - issue_valid_o = 0
  - issue_addr_o = 0
  - occupancy_o = 0
  - drop_count_o = 0
  - head and tail pointers = 0
  - all entry valid state
- Release of rst is synchronized by the integrator. Inputs are ignored in any cycle where rst is low.
- Latency: a candidate accepted at edge N appears on issue_addr_o after edge N if the FIFO was empty. Otherwise it appears after all older entries drain.
- Throughput: one issue per cycle at most; up to three enqueues per cycle.
- Full FIFO with simultaneous pop: all new candidates are dropped, and occupancy becomes DEPTH−1.
- Empty FIFO with issue_ready_i high: no pop, and no effect.
- Reset mid-burst: all queued entries are lost. drop_count_o does not count them.

## Configuration
- PREF_ISSUE_QUEUE_DEDUP_EN:
  - Defined: the duplicate filter is active as described above.
  - Undefined: there is no compare logic. Every valid candidate is enqueued subject only to space, so identical aligned addresses may occupy several entries.
- Capacity drop counting is identical in both builds.

## Test plan
- Single candidate: reset, then valid1 = 1 with addr1 = 0x1047 for one cycle, issue_ready_i = 0.
  - Next cycle: issue_valid_o = 1, issue_addr_o = 0x1040, occupancy_o = 1.
  - Then raise ready for one cycle: occupancy_o = 0 and issue_valid_o = 0.
- Burst order: one cycle with all three valid, addresses 0x2000, 0x2040, 0x2080, ready held high.
  - Issues 0x2000, 0x2040, 0x2080 on three consecutive cycles.
- Overflow (DEPTH = 8, ready = 0): three cycles of three distinct candidates each.
  - Result: occupancy_o = 8 and drop_count_o = 1; the 9th candidate is dropped and the first 8 are retained in order.
- Full with pop: same state as Overflow, ready = 1 plus three new candidates.
  - Result: occupancy_o = 7 and drop_count_o = 4.
- Dedup (macro defined): queue holds 0x3000; candidates 0x3010, 0x3040, 0x3050.
  - Only 0x3040 is enqueued, and drop_count_o is unchanged.
  - Same stimulus with the macro undefined: all three are enqueued.
- Async reset mid-operation: with occupancy_o = 5, assert rst low between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first new candidate issues after one edge.

Source files
------------

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: block-aligns up to three candidates per cycle into a circular FIFO and issues one per cycle.
// Optional duplicate filter is enabled by defining PREF_ISSUE_QUEUE_DEDUP_EN.
module pref_issue_queue #(
  parameter int DEPTH           = 8,
  parameter int ADDR_SIZE       = 64,
  parameter int LOG2_BLOCK_SIZE = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_SIZE-1:0]    pref_addr1_i,
  input  logic [ADDR_SIZE-1:0]    pref_addr2_i,
  input  logic [ADDR_SIZE-1:0]    pref_addr3_i,
  input  logic                    pref_valid1_i,
  input  logic                    pref_valid2_i,
  input  logic                    pref_valid3_i,
  output logic                    issue_valid_o,
  output logic [ADDR_SIZE-1:0]    issue_addr_o,
  input  logic                    issue_ready_i,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic [15:0]             drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef logic [ADDR_SIZE-1:0] addr_t;

  localparam addr_t BLK_MASK = addr_t'((64'd1 << LOG2_BLOCK_SIZE) - 64'd1);

  addr_t            entry_q [DEPTH];
  addr_t            entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] free_w;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      drop_sum;
  logic             issue_valid_q, issue_valid_d;
  addr_t            issue_addr_q, issue_addr_d;

  addr_t            cand [3];
  logic [2:0]       cand_v;
  logic [2:0]       keep;
  logic [2:0]       acc;
  logic [1:0]       enq_cnt;
  logic [1:0]       drop_inc;
  logic             pop;

  assign cand[0] = pref_addr1_i & ~BLK_MASK;
  assign cand[1] = pref_addr2_i & ~BLK_MASK;
  assign cand[2] = pref_addr3_i & ~BLK_MASK;
  assign cand_v  = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

  // Handshake: the head transfers on a rising edge where issue_valid_o && issue_ready_i;
  // issue_valid_o/issue_addr_o are registered and stay put while ready is low.
  always_comb begin
    entry_d  = entry_q;
    keep     = cand_v;
    acc      = '0;
    enq_cnt  = '0;
    drop_inc = '0;
    free_w   = OCC_W'(DEPTH) - occ_q;
    pop      = issue_valid_q && issue_ready_i;
    for (int i = 0; i < 3; i++) begin
`ifdef PREF_ISSUE_QUEUE_DEDUP_EN
      // Compare against entries valid at the start of the cycle, popping head included.
      for (int j = 0; j < DEPTH; j++) begin
        if ((OCC_W'(PTR_W'(PTR_W'(j) - head_q)) < occ_q) && (entry_q[j] == cand[i])) begin
          keep[i] = 1'b0;
        end
      end
      for (int k = 0; k < i; k++) begin
        if (acc[k] && (cand[k] == cand[i])) begin
          keep[i] = 1'b0;
        end
      end
`endif
      if (keep[i]) begin
        if (OCC_W'(enq_cnt) < free_w) begin
          entry_d[tail_q + PTR_W'(enq_cnt)] = cand[i];
          acc[i]  = 1'b1;
          enq_cnt = enq_cnt + 2'd1;
        end else begin
          drop_inc = drop_inc + 2'd1;
        end
      end
    end
    head_d        = head_q + PTR_W'(pop);
    tail_d        = tail_q + PTR_W'(enq_cnt);
    occ_d         = occ_q + OCC_W'(enq_cnt) - OCC_W'(pop);
    drop_sum      = {1'b0, drop_q} + 17'(drop_inc);
    drop_d        = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    issue_valid_d = (occ_d != '0);
    issue_addr_d  = entry_d[head_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
      drop_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
      drop_q        <= drop_d;
      issue_valid_q <= issue_valid_d;
      issue_addr_q  <= issue_addr_d;
    end
  end

  // Entry payload needs no reset: validity is fully described by head_q/occ_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_addr_o  = issue_addr_q;
  assign occupancy_o   = occ_q;
  assign drop_count_o  = drop_q;

endmodule
